// File: rtl/ex_mem.sv
// EX/MEM pipeline register: captures execute results, applies flush/bubble/hold rules, counts bubbles.
// With EXMEM_MADD_EN defined it also holds the madd/msub partial product and cycle count; otherwise those outputs are tied to 0.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_rw,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_rw,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o,
  output logic [15:0] bubble_cnt
);

  logic [4:0]  rw_d,    rw_q;
  logic        wreg_d,  wreg_q;
  logic [31:0] wdata_d, wdata_q;
  logic        whilo_d, whilo_q;
  logic [31:0] hi_d,    hi_q;
  logic [31:0] lo_d,    lo_q;
  logic [15:0] bub_d,   bub_q;

  logic bubble, advance;
  assign bubble  = stall[3] & ~stall[4];
  assign advance = ~stall[3];

  always_comb begin
    rw_d    = rw_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    bub_d   = bub_q;
    if (rst) begin
      rw_d = '0; wreg_d = 1'b0; wdata_d = '0; whilo_d = 1'b0; hi_d = '0; lo_d = '0;
      bub_d = '0;
    end else if (flush) begin
      rw_d = '0; wreg_d = 1'b0; wdata_d = '0; whilo_d = 1'b0; hi_d = '0; lo_d = '0;
    end else if (bubble) begin
      // Memory stage sees a NOP while execute holds its instruction.
      rw_d = '0; wreg_d = 1'b0; wdata_d = '0; whilo_d = 1'b0; hi_d = '0; lo_d = '0;
      if (bub_q != 16'hFFFF) bub_d = bub_q + 16'd1;
    end else if (advance) begin
      rw_d    = ex_rw;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      whilo_d = ex_whilo;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
    end
  end

  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    wreg_q  <= wreg_d;
    wdata_q <= wdata_d;
    whilo_q <= whilo_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    bub_q   <= bub_d;
  end

  assign mem_rw     = rw_q;
  assign mem_wreg   = wreg_q;
  assign mem_wdata  = wdata_q;
  assign mem_whilo  = whilo_q;
  assign mem_hi     = hi_q;
  assign mem_lo     = lo_q;
  assign bubble_cnt = bub_q;

`ifdef EXMEM_MADD_EN
  logic [63:0] hilo_d, hilo_q;
  logic [1:0]  cnt_d,  cnt_q;

  // Product survives only across a bubble; any advance or flush drops it.
  always_comb begin
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    if (rst || flush) begin
      hilo_d = '0;
      cnt_d  = '0;
    end else if (bubble) begin
      hilo_d = hilo_i;
      cnt_d  = cnt_i;
    end else if (advance) begin
      hilo_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    hilo_q <= hilo_d;
    cnt_q  <= cnt_d;
  end

  assign hilo_o = hilo_q;
  assign cnt_o  = cnt_q;
`else
  logic unused_madd;
  assign unused_madd = ^{hilo_i, cnt_i};
  assign hilo_o = '0;
  assign cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  stall;
  logic [4:0]  ex_rw;
  logic        ex_wreg, ex_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_rw;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the memory stage should see, kept as plain values.
  int          m_rw, m_wdata_dummy;
  logic [31:0] m_wdata, m_hi, m_lo;
  logic        m_wreg, m_whilo;
  logic [63:0] m_hilo;
  int          m_cnt;
  int          m_bub;
`ifdef EXMEM_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_rw(ex_rw), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_rw(mem_rw), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .hilo_o(hilo_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_stage;
    m_rw = 0; m_wreg = 0; m_wdata = 0; m_whilo = 0; m_hi = 0; m_lo = 0;
  endtask

  task automatic model_edge;
    if (rst) begin
      clear_stage(); m_hilo = 0; m_cnt = 0; m_bub = 0;
    end else if (flush) begin
      clear_stage(); m_hilo = 0; m_cnt = 0;
    end else if (stall[3] && !stall[4]) begin
      clear_stage();
      m_hilo = MADD ? hilo_i : 64'd0;
      m_cnt  = MADD ? int'(cnt_i) : 0;
      m_bub  = (m_bub + 1 > 65535) ? 65535 : m_bub + 1;
    end else if (!stall[3]) begin
      m_rw = ex_rw; m_wreg = ex_wreg; m_wdata = ex_wdata;
      m_whilo = ex_whilo; m_hi = ex_hi; m_lo = ex_lo;
      m_hilo = 0; m_cnt = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rw"},    64'(mem_rw),     64'(m_rw));
    chk({tag, ".wreg"},  64'(mem_wreg),   64'(m_wreg));
    chk({tag, ".wdata"}, 64'(mem_wdata),  64'(m_wdata));
    chk({tag, ".whilo"}, 64'(mem_whilo),  64'(m_whilo));
    chk({tag, ".hi"},    64'(mem_hi),     64'(m_hi));
    chk({tag, ".lo"},    64'(mem_lo),     64'(m_lo));
    chk({tag, ".hilo"},  hilo_o,          m_hilo);
    chk({tag, ".cnt"},   64'(cnt_o),      64'(m_cnt));
    chk({tag, ".bub"},   64'(bubble_cnt), 64'(m_bub));
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic cyc(input string tag, input bit do_check);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (do_check) check_all(tag);
  endtask

  task automatic rand_ex;
    ex_rw = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
    ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
    hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
  endtask

  initial begin
    int bub_saved;
    m_rw = 0; m_wdata_dummy = 0;
    m_wreg = 1'bx; m_wdata = 'x; m_whilo = 1'bx; m_hi = 'x; m_lo = 'x;
    m_hilo = 'x; m_cnt = 0; m_bub = 0;

    // Reset for two edges with junk on the inputs.
    rst = 1; flush = 0; stall = 6'b0;
    ex_rw = 5'd7; ex_wreg = 1; ex_wdata = 32'hDEADBEEF; ex_whilo = 1;
    ex_hi = 32'h11111111; ex_lo = 32'h22222222; hilo_i = 64'h5; cnt_i = 2'd1;
    cyc("reset1", 1);
    chk("reset1.wdata_zero", 64'(mem_wdata), 64'd0);
    cyc("reset2", 1);
    chk("reset2.bub_zero", 64'(bubble_cnt), 64'd0);
    rst = 0;

    // Pass-through.
    stall = 6'b0; ex_rw = 5'd3; ex_wreg = 1; ex_wdata = 32'h12345678;
    ex_whilo = 0; ex_hi = 0; ex_lo = 0;
    cyc("pass", 1);
    chk("pass.const_rw", 64'(mem_rw), 64'd3);
    chk("pass.const_wdata", 64'(mem_wdata), 64'h12345678);
    chk("pass.const_bub", 64'(bubble_cnt), 64'd0);

    // Bubble with a madd first cycle, then advance.
    stall = 6'b001111; ex_wreg = 1; ex_whilo = 1;
    hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    cyc("bubble", 1);
    chk("bubble.const_wreg", 64'(mem_wreg), 64'd0);
    chk("bubble.const_hilo", hilo_o, MADD ? 64'h1_0000_0002 : 64'd0);
    chk("bubble.const_cnt", 64'(cnt_o), MADD ? 64'd1 : 64'd0);
    chk("bubble.const_bub", 64'(bubble_cnt), 64'd1);
    stall = 6'b0; hilo_i = 64'hFFFF; cnt_i = 2'd2;
    cyc("advance", 1);
    chk("advance.const_hilo", hilo_o, 64'd0);
    chk("advance.const_cnt", 64'(cnt_o), 64'd0);

    // Hold: memory stage keeps its contents while execute data churns.
    ex_wdata = 32'hA5A5A5A5;
    cyc("load", 1);
    bub_saved = m_bub;
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = $urandom;
      cyc("hold", 1);
      chk("hold.const_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
    end
    chk("hold.bub_same", 64'(bubble_cnt), 64'(bub_saved));

    // Flush beats a bubble and discards any partial product.
    stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'h1234;
    cyc("pre_flush", 1);
    bub_saved = m_bub;
    flush = 1;
    cyc("flush", 1);
    chk("flush.const_cnt", 64'(cnt_o), 64'd0);
    chk("flush.bub_same", 64'(bubble_cnt), 64'(bub_saved));
    flush = 0;

    // Randomised legal traffic.
    for (int i = 0; i < 300; i++) begin
      rand_ex();
      case ($urandom_range(2, 0))
        0: stall = 6'b000000;
        1: stall = 6'b001111;
        default: stall = 6'b011111;
      endcase
      flush = ($urandom_range(7, 0) == 0);
      rst   = ($urandom_range(63, 0) == 0);
      cyc("rand", 1);
    end
    rst = 0; flush = 0;

    // Saturation: drive the counter to its ceiling and one beyond.
    stall = 6'b001111;
    while (m_bub < 65535) cyc("sat_fill", 0);
    check_all("sat_full");
    chk("sat.const_full", 64'(bubble_cnt), 64'hFFFF);
    cyc("sat_over", 1);
    chk("sat.const_over", 64'(bubble_cnt), 64'hFFFF);
    stall = 6'b0;
    cyc("sat_adv", 1);
    chk("sat.const_adv", 64'(bubble_cnt), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
